hilo_result_sel: RTL and testbench

- Registered successor to the execute-stage result selector.
- Picks the writeback value from ALU, shifter, HI or LO, and owns the HI/LO register pair.
- Tracks an external multi-cycle DIVU unit and stalls the pipeline on MFHI/MFLO while a division is in flight.
- Sits between the EX datapath units and the EX/MEM pipeline register.

---
 rtl/hilo_result_sel.sv | 164 ++++++++++++++++
 tb/tb_hilo_result_sel.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_result_sel.sv
`default_nettype none
// ============================================================================
// Module      : hilo_result_sel
// Description : Registered execute-stage result selector. Picks the writeback
//               value from ALU, shifter, HI or LO, owns the HI/LO register
//               pair and tracks an external multi-cycle DIVU unit, stalling
//               MFHI/MFLO/DIVU while a division is in flight.
//               Optional macro HILO_MOVE_EN adds MTHI/MTLO decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_result_sel #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [WIDTH-1:0]   shift_out,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   div_quot,
  input  logic [WIDTH-1:0]   div_rem,
  input  logic               div_done,
  output logic               div_start,
  output logic               stall,
  output logic [WIDTH-1:0]   data_out,
  output logic               out_valid,
  output logic [WIDTH-1:0]   hi_q,
  output logic [WIDTH-1:0]   lo_q
);

  localparam logic [FUNCT_W-1:0] c_f_and  = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] c_f_or   = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] c_f_add  = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] c_f_sub  = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] c_f_slt  = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] c_f_sll  = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] c_f_mfhi = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] c_f_mflo = FUNCT_W'(6'b010010);
  localparam logic [FUNCT_W-1:0] c_f_divu = FUNCT_W'(6'b011011);
`ifdef HILO_MOVE_EN
  localparam logic [FUNCT_W-1:0] c_f_mthi = FUNCT_W'(6'b010001);
  localparam logic [FUNCT_W-1:0] c_f_mtlo = FUNCT_W'(6'b010011);
`endif

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_DIV_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_out_valid;
  logic             r_div_start;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_sel;
  logic             w_writes;    // op produces a GPR write
  logic             w_is_divu;
  logic             w_is_hilo;   // op must wait for an in-flight division
  logic             w_mthi;
  logic             w_mtlo;
  logic             w_accept;

`ifndef HILO_MOVE_EN
  // rs_data only feeds the move ops; fold it away when they are absent
  logic w_unused_rs;
  assign w_unused_rs = ^rs_data;
`endif

  // Decode funct into the selected value and per-op control flags
  always_comb begin
    w_sel     = '0;
    w_writes  = 1'b1;
    w_is_divu = 1'b0;
    w_is_hilo = 1'b0;
    w_mthi    = 1'b0;
    w_mtlo    = 1'b0;
    case (funct)
      c_f_and, c_f_or, c_f_add, c_f_sub, c_f_slt: w_sel = alu_out;
      c_f_sll: w_sel = shift_out;
      c_f_mfhi: begin
        w_sel     = r_hi;
        w_is_hilo = 1'b1;
      end
      c_f_mflo: begin
        w_sel     = r_lo;
        w_is_hilo = 1'b1;
      end
      c_f_divu: begin
        w_writes  = 1'b0;
        w_is_divu = 1'b1;
        w_is_hilo = 1'b1;
      end
`ifdef HILO_MOVE_EN
      c_f_mthi: begin
        w_writes  = 1'b0;
        w_mthi    = 1'b1;
        w_is_hilo = 1'b1;
      end
      c_f_mtlo: begin
        w_writes  = 1'b0;
        w_mtlo    = 1'b1;
        w_is_hilo = 1'b1;
      end
`endif
      default: w_sel = '0;  // legacy behaviour: unknown codes write zero
    endcase
  end

  assign stall    = in_valid & (r_state == ST_DIV_WAIT) & w_is_hilo;
  assign w_accept = in_valid & ~stall;

  // Result register, HI/LO pair and divider-tracking state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_out_valid <= 1'b0;
      r_div_start <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_out_valid <= w_accept & w_writes;
      r_div_start <= w_accept & w_is_divu;
      if (w_accept) begin
        r_data <= w_sel;
      end
      case (r_state)
        ST_IDLE: begin
          // a DIVU can only be accepted here since it stalls in DIV_WAIT
          if (w_accept && w_is_divu) begin
            r_state <= ST_DIV_WAIT;
          end
        end
        ST_DIV_WAIT: begin
          if (div_done) begin
            r_hi    <= div_rem;
            r_lo    <= div_quot;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // MT* stalls in DIV_WAIT, so it never collides with a div_done write
      if (w_accept && w_mthi) begin
        r_hi <= rs_data;
      end
      if (w_accept && w_mtlo) begin
        r_lo <= rs_data;
      end
    end
  end

  assign data_out  = r_data;
  assign out_valid = r_out_valid;
  assign div_start = r_div_start;
  assign hi_q      = r_hi;
  assign lo_q      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_result_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_result_sel
// Description : Self-checking bench for hilo_result_sel. Expected writeback
//               values are queued when an op is issued and popped by a
//               monitor whenever out_valid rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_result_sel;

  localparam int WIDTH   = 32;
  localparam int FUNCT_W = 6;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MTLO = 6'b010011;
  localparam logic [5:0] F_BAD  = 6'b111111;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [5:0]       funct;
  logic [WIDTH-1:0] alu_out, shift_out, rs_data, div_quot, div_rem;
  logic             div_done;
  logic             div_start, stall, out_valid;
  logic [WIDTH-1:0] data_out, hi_q, lo_q;

  int n_pass  = 0;
  int n_total = 0;
  logic [WIDTH-1:0] exp_q[$];

  hilo_result_sel #(.WIDTH(WIDTH), .FUNCT_W(FUNCT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .funct    (funct),
    .alu_out  (alu_out),
    .shift_out(shift_out),
    .rs_data  (rs_data),
    .div_quot (div_quot),
    .div_rem  (div_rem),
    .div_done (div_done),
    .div_start(div_start),
    .stall    (stall),
    .data_out (data_out),
    .out_valid(out_valid),
    .hi_q     (hi_q),
    .lo_q     (lo_q)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every writeback must match the oldest queued value
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL writeback: unexpected out_valid, data_out=%h, required no output", data_out);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) $display("FAIL writeback: data_out=%h required %h", data_out, e);
        else n_pass++;
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r);
    @(negedge clk);
    in_valid = 1'b1; funct = f; alu_out = a; shift_out = s; rs_data = r; div_done = 1'b0;
    #1;
  endtask

  task automatic bubble();
    @(negedge clk);
    in_valid = 1'b0; div_done = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; funct = '0; alu_out = '0; shift_out = '0;
    rs_data = '0; div_quot = '0; div_rem = '0; div_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({data_out, out_valid, div_start, hi_q, lo_q, stall} !== '0)
      $display("FAIL reset: data=%h v=%b ds=%b hi=%h lo=%h st=%b, required all 0",
               data_out, out_valid, div_start, hi_q, lo_q, stall);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu_sel();
    issue(F_ADD, 32'h7, 32'h0, 32'h0);
    exp_q.push_back(32'h7);
    @(posedge clk); #1;
    n_total++;
    if (hi_q !== '0 || lo_q !== '0) $display("FAIL add_hilo: hi=%h lo=%h required 0", hi_q, lo_q);
    else n_pass++;
    issue(F_SLL, 32'h1, 32'h8000_0000, 32'h0); exp_q.push_back(32'h8000_0000);
    issue(F_AND, 32'h0000_1234, 32'h5, 32'h0); exp_q.push_back(32'h0000_1234);
    issue(F_SUB, 32'hFFFF_FFFE, 32'h5, 32'h0); exp_q.push_back(32'hFFFF_FFFE);
    issue(F_SLT, 32'h1, 32'h5, 32'h0);         exp_q.push_back(32'h1);
    issue(F_BAD, 32'hDEAD_BEEF, 32'h5, 32'h0); exp_q.push_back(32'h0);
    bubble();
    bubble();
  endtask

  task automatic test_divu_mflo();
    issue(F_DIVU, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    n_total++;
    if (div_start !== 1'b1) $display("FAIL div_start_pulse: div_start=%b required 1", div_start);
    else n_pass++;
    issue(F_MFLO, 32'h0, 32'h0, 32'h0);
    n_total++;
    if (stall !== 1'b1) $display("FAIL mflo_stall: stall=%b required 1", stall);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (div_start !== 1'b0) $display("FAIL div_start_single: div_start=%b required 0", div_start);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_total++;
      if (stall !== 1'b1) $display("FAIL mflo_stall_hold: cycle %0d stall=%b required 1", i, stall);
      else n_pass++;
    end
    @(negedge clk);
    div_done = 1'b1; div_quot = 32'h3; div_rem = 32'h1;
    #1;
    n_total++;
    if (stall !== 1'b1) $display("FAIL stall_on_done: stall=%b required 1", stall);
    else n_pass++;
    @(negedge clk);
    div_done = 1'b0;
    #1;
    n_total++;
    if (stall !== 1'b0 || hi_q !== 32'h1 || lo_q !== 32'h3)
      $display("FAIL div_result: stall=%b hi=%h lo=%h required 0/00000001/00000003", stall, hi_q, lo_q);
    else n_pass++;
    exp_q.push_back(32'h3);
    bubble();
    bubble();
  endtask

  task automatic test_back_to_back();
    issue(F_DIVU, 32'h0, 32'h0, 32'h0);
    issue(F_OR, 32'hF0, 32'h0, 32'h0);
    n_total++;
    if (stall !== 1'b0) $display("FAIL or_no_stall: stall=%b required 0", stall);
    else n_pass++;
    exp_q.push_back(32'hF0);
    issue(F_MFHI, 32'h0, 32'h0, 32'h0);
    n_total++;
    if (stall !== 1'b1) $display("FAIL mfhi_stall: stall=%b required 1", stall);
    else n_pass++;
    issue(F_DIVU, 32'h0, 32'h0, 32'h0);
    n_total++;
    if (stall !== 1'b1) $display("FAIL divu_stall: stall=%b required 1", stall);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (div_start !== 1'b0) $display("FAIL second_divu_start: div_start=%b required 0", div_start);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0; div_done = 1'b1; div_quot = 32'h55; div_rem = 32'hAA;
    @(posedge clk); #1;
    n_total++;
    if (hi_q !== 32'hAA || lo_q !== 32'h55)
      $display("FAIL div2_result: hi=%h lo=%h required 000000aa/00000055", hi_q, lo_q);
    else n_pass++;
    issue(F_MFHI, 32'h0, 32'h0, 32'h0); exp_q.push_back(32'hAA);
    issue(F_MFLO, 32'h0, 32'h0, 32'h0); exp_q.push_back(32'h55);
    bubble();
  endtask

  task automatic test_idle_done();
    @(negedge clk);
    in_valid = 1'b0; div_done = 1'b1; div_quot = $urandom; div_rem = $urandom;
    @(posedge clk); #1;
    n_total++;
    if (hi_q !== 32'hAA || lo_q !== 32'h55)
      $display("FAIL idle_done: hi=%h lo=%h required 000000aa/00000055", hi_q, lo_q);
    else n_pass++;
    bubble();
  endtask

  task automatic test_move();
    issue(F_MTHI, 32'h0, 32'h0, 32'hABCD);
`ifndef HILO_MOVE_EN
    exp_q.push_back(32'h0);
`endif
    @(posedge clk); #1;
    n_total++;
`ifdef HILO_MOVE_EN
    if (hi_q !== 32'hABCD) $display("FAIL mthi: hi=%h required 0000abcd", hi_q);
    else n_pass++;
`else
    if (hi_q !== 32'hAA) $display("FAIL mthi_off: hi=%h required 000000aa", hi_q);
    else n_pass++;
`endif
    issue(F_MTLO, 32'h0, 32'h0, 32'h1234);
`ifndef HILO_MOVE_EN
    exp_q.push_back(32'h0);
`endif
    @(posedge clk); #1;
    n_total++;
`ifdef HILO_MOVE_EN
    if (lo_q !== 32'h1234) $display("FAIL mtlo: lo=%h required 00001234", lo_q);
    else n_pass++;
`else
    if (lo_q !== 32'h55) $display("FAIL mtlo_off: lo=%h required 00000055", lo_q);
    else n_pass++;
`endif
    bubble();
    bubble();
  endtask

  task automatic test_reset_mid_div();
    issue(F_DIVU, 32'h0, 32'h0, 32'h0);
    bubble();
    bubble();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (hi_q !== '0 || lo_q !== '0 || div_start !== 1'b0)
      $display("FAIL reset_mid: hi=%h lo=%h ds=%b required 0", hi_q, lo_q, div_start);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    div_done = 1'b1; div_quot = 32'h77; div_rem = 32'h66;
    @(posedge clk); #1;
    n_total++;
    if (hi_q !== '0 || lo_q !== '0)
      $display("FAIL late_done: hi=%h lo=%h required 0", hi_q, lo_q);
    else n_pass++;
    issue(F_MFHI, 32'h0, 32'h0, 32'h0);
    n_total++;
    if (stall !== 1'b0) $display("FAIL mfhi_after_reset_stall: stall=%b required 0", stall);
    else n_pass++;
    exp_q.push_back(32'h0);
    bubble();
    bubble();
  endtask

  initial begin
    test_reset();
    test_alu_sel();
    test_divu_mflo();
    test_back_to_back();
    test_idle_done();
    test_move();
    test_reset_mid_div();
    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d writebacks missing, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
